// File: rtl/sha3_result_collector.sv
// rtl/sha3_result_collector.sv - captures SHA3 scan completions into a small result FIFO with stats
module sha3_result_collector #(
  parameter int DEPTH        = 2,
  parameter bit STORE_MISSES = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_ready,
  input  logic                     s_found,
  input  logic [31:0]              s_nonce,
  input  logic [25*64-1:0]         s_hash,
  output logic                     res_valid,
  input  logic                     res_pop,
  input  logic [5:0]               rd_sel,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   res_level,
  output logic                     overflow,
  output logic [31:0]              completed_count,
  output logic [31:0]              found_count,
  input  logic                     clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  // Entry storage; the hash is kept as 50 words so rd_sel indexes it directly.
  logic [49:0][31:0] hash_mem  [DEPTH];
  logic [31:0]       nonce_mem [DEPTH];
  logic              found_mem [DEPTH];

  logic          ready_q, ready_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   completed_q, completed_d;
  logic [31:0]   found_cnt_q, found_cnt_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic              event_w, store_w, full_w, empty_w;
  logic              do_pop, do_push, drop_w;
  logic [49:0][31:0] head_words;

  // Completion detection and FIFO push/pop decisions.
  always_comb begin
    event_w = s_ready & ~ready_q;
    store_w = event_w & (STORE_MISSES | s_found);
    full_w  = (level_q == FULL);
    empty_w = (level_q == '0);
    do_pop  = res_pop & ~empty_w;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    do_push = store_w & (~full_w | do_pop);
    drop_w  = store_w & full_w & ~do_pop;
  end

  // Next-state for pointers, level, statistics and the registered read word.
  always_comb begin
    ready_d     = s_ready;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    completed_d = completed_q;
    found_cnt_d = found_cnt_q;
    rd_data_d   = '0;
    head_words  = hash_mem[rd_ptr_q];

    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + LW'(1);
    else if (do_pop && !do_push) level_d = level_q - LW'(1);

    // Clear wins over a same-cycle event for the statistics only.
    if (clear) begin
      overflow_d  = 1'b0;
      completed_d = '0;
      found_cnt_d = '0;
    end else begin
      overflow_d  = overflow_q | drop_w;
      completed_d = completed_q + {31'b0, event_w};
      found_cnt_d = found_cnt_q + {31'b0, event_w & s_found};
    end

    // Read word comes from the head as it stands before this edge's pop.
    if (!empty_w) begin
      if (rd_sel < 6'd50)       rd_data_d = head_words[rd_sel];
      else if (rd_sel == 6'd50) rd_data_d = nonce_mem[rd_ptr_q];
      else if (rd_sel == 6'd51) rd_data_d = {31'b0, found_mem[rd_ptr_q]};
    end
  end

  // Control state; ready history resets high so a ready held through reset is not a completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q     <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      completed_q <= '0;
      found_cnt_q <= '0;
      rd_data_q   <= '0;
    end else begin
      ready_q     <= ready_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      completed_q <= completed_d;
      found_cnt_q <= found_cnt_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Entry payload write; contents need no reset because an empty FIFO reads zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      hash_mem[wr_ptr_q]  <= s_hash;
      nonce_mem[wr_ptr_q] <= s_nonce;
      found_mem[wr_ptr_q] <= s_found;
    end
  end

  assign res_valid       = ~empty_w;
  assign res_level       = level_q;
  assign rd_data         = rd_data_q;
  assign overflow        = overflow_q;
  assign completed_count = completed_q;
  assign found_count     = found_cnt_q;

endmodule

// File: tb/tb_sha3_result_collector.sv
// tb/tb_sha3_result_collector.sv - scoreboard bench for sha3_result_collector
module tb_sha3_result_collector;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_ready, s_found, res_pop, clear;
  logic [31:0]   s_nonce;
  logic [1599:0] s_hash;
  logic [5:0]    rd_sel;

  logic          res_valid, overflow;
  logic [31:0]   rd_data, completed_count, found_count;
  logic [1:0]    res_level;

  logic          res_valid_m, overflow_m;
  logic [31:0]   rd_data_m, completed_count_m, found_count_m;
  logic [1:0]    res_level_m;

  always #5 clk = ~clk;

  sha3_result_collector #(.DEPTH(2), .STORE_MISSES(1'b0)) dut (
    .clk(clk), .rst(rst), .s_ready(s_ready), .s_found(s_found), .s_nonce(s_nonce),
    .s_hash(s_hash), .res_valid(res_valid), .res_pop(res_pop), .rd_sel(rd_sel),
    .rd_data(rd_data), .res_level(res_level), .overflow(overflow),
    .completed_count(completed_count), .found_count(found_count), .clear(clear));

  sha3_result_collector #(.DEPTH(2), .STORE_MISSES(1'b1)) dut_m (
    .clk(clk), .rst(rst), .s_ready(s_ready), .s_found(s_found), .s_nonce(s_nonce),
    .s_hash(s_hash), .res_valid(res_valid_m), .res_pop(res_pop), .rd_sel(rd_sel),
    .rd_data(rd_data_m), .res_level(res_level_m), .overflow(overflow_m),
    .completed_count(completed_count_m), .found_count(found_count_m), .clear(clear));

  typedef struct {
    logic          found;
    logic [31:0]   nonce;
    logic [1599:0] hash;
  } ent_t;

  ent_t        sb[$];
  logic        m_ovf;
  logic [31:0] m_cnt, m_fnd;
  int          total = 0;
  int          bad = 0;

  localparam int SELS [8] = '{50, 51, 0, 1, 6, 7, 49, 55};

  function automatic logic [1599:0] mk_hash(input logic [31:0] n);
    logic [1599:0] h;
    for (int w = 0; w < 50; w++)
      h[w*32 +: 32] = (n * 32'h9E3779B1) ^ (32'(w) * 32'h01010101) ^ 32'hA5A50000;
    return h;
  endfunction

  // Word map: word 2k is the low half of hash lane k, 2k+1 the high half.
  function automatic logic [31:0] exp_word(input ent_t e, input int sel);
    if (sel < 50)  return e.hash[sel*32 +: 32];
    if (sel == 50) return e.nonce;
    if (sel == 51) return {31'b0, e.found};
    return 32'h0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic read_word(input int sel, output logic [31:0] d);
    rd_sel = 6'(sel);
    tick();
    d = rd_data;
  endtask

  task automatic do_reset;
    rst = 1'b0; s_ready = 1'b1; s_found = 1'b0; s_nonce = '0; s_hash = '0;
    res_pop = 1'b0; rd_sel = '0; clear = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    sb.delete(); m_ovf = 1'b0; m_cnt = '0; m_fnd = '0;
  endtask

  // One scanner completion; the model tracks the STORE_MISSES=0 instance.
  task automatic complete(input logic f, input logic [31:0] n, input logic [1599:0] h,
                          input logic pop, input logic clr);
    ent_t e;
    s_ready = 1'b0;
    tick();
    s_found = f; s_nonce = n; s_hash = h; s_ready = 1'b1; res_pop = pop; clear = clr;
    tick();
    res_pop = 1'b0; clear = 1'b0;
    if (pop && sb.size() > 0) void'(sb.pop_front());
    if (f) begin
      e.found = f; e.nonce = n; e.hash = h;
      if (sb.size() < 2) sb.push_back(e);
      else m_ovf = 1'b1;
    end
    if (clr) begin
      m_cnt = '0; m_fnd = '0; m_ovf = 1'b0;
    end else begin
      m_cnt = m_cnt + 1;
      m_fnd = m_fnd + {31'b0, f};
    end
  endtask

  task automatic pop_one;
    res_pop = 1'b1;
    tick();
    res_pop = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic test_reset;
    do_reset();
    tick(); tick();
    total += 5;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", res_valid); end
    if (res_level !== 2'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", res_level); end
    if (completed_count !== 32'd0) begin bad++; $display("FAIL reset_completed got=%0d exp=0", completed_count); end
    if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
  endtask

  task automatic test_single;
    logic [1599:0] h;
    logic [31:0]   d;
    int            sel_t [5] = '{50, 6, 7, 51, 60};
    logic [31:0]   exp_t [5] = '{32'hDEADBEEF, 32'h89ABCDEF, 32'h01234567, 32'h1, 32'h0};
    do_reset();
    h = mk_hash(32'hDEADBEEF);
    h[3*64 +: 64] = 64'h0123456789ABCDEF;
    complete(1'b1, 32'hDEADBEEF, h, 1'b0, 1'b0);
    total += 3;
    if (res_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", res_valid); end
    if (res_level !== 2'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", res_level); end
    if (found_count !== 32'd1) begin bad++; $display("FAIL single_found got=%0d exp=1", found_count); end
    for (int i = 0; i < 5; i++) begin
      read_word(sel_t[i], d);
      total++;
      if (d !== exp_t[i]) begin bad++; $display("FAIL single_word sel=%0d got=%h exp=%h", sel_t[i], d, exp_t[i]); end
    end
    pop_one();
    read_word(50, d);
    total += 2;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%0b exp=0", res_valid); end
    if (d !== 32'h0) begin bad++; $display("FAIL single_empty_read got=%h exp=0", d); end
  endtask

  task automatic test_misses;
    do_reset();
    for (int i = 1; i <= 3; i++) complete(1'b0, 32'(i), mk_hash(32'(i)), 1'b0, 1'b0);
    total += 6;
    if (res_level !== 2'd0) begin bad++; $display("FAIL miss_level got=%0d exp=0", res_level); end
    if (completed_count !== m_cnt) begin bad++; $display("FAIL miss_completed got=%0d exp=%0d", completed_count, m_cnt); end
    if (found_count !== 32'd0) begin bad++; $display("FAIL miss_found got=%0d exp=0", found_count); end
    if (res_level_m !== 2'd2) begin bad++; $display("FAIL missall_level got=%0d exp=2", res_level_m); end
    if (overflow_m !== 1'b1) begin bad++; $display("FAIL missall_overflow got=%0b exp=1", overflow_m); end
    if (completed_count_m !== 32'd3) begin bad++; $display("FAIL missall_completed got=%0d exp=3", completed_count_m); end
  endtask

  task automatic drain(input string tag);
    logic [31:0] d, e;
    while (sb.size() > 0) begin
      for (int i = 0; i < 8; i++) begin
        read_word(SELS[i], d);
        e = exp_word(sb[0], SELS[i]);
        total++;
        if (d !== e) begin bad++; $display("FAIL %s_word sel=%0d got=%h exp=%h", tag, SELS[i], d, e); end
      end
      pop_one();
      total++;
      if (res_level !== 2'(sb.size())) begin bad++; $display("FAIL %s_level got=%0d exp=%0d", tag, res_level, sb.size()); end
    end
  endtask

  task automatic test_pop_on_full;
    logic [31:0] d;
    do_reset();
    complete(1'b1, 32'd1, mk_hash(32'd1), 1'b0, 1'b0);
    complete(1'b1, 32'd2, mk_hash(32'd2), 1'b0, 1'b0);
    complete(1'b1, 32'd3, mk_hash(32'd3), 1'b1, 1'b0);
    read_word(50, d);
    total += 4;
    if (res_level !== 2'd2) begin bad++; $display("FAIL popfull_level got=%0d exp=2", res_level); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL popfull_overflow got=%0b exp=0", overflow); end
    if (d !== 32'd2) begin bad++; $display("FAIL popfull_head got=%0d exp=2", d); end
    if (completed_count !== m_cnt) begin bad++; $display("FAIL popfull_completed got=%0d exp=%0d", completed_count, m_cnt); end
    drain("popfull");
  endtask

  task automatic test_overflow_clear;
    logic [31:0] d;
    do_reset();
    complete(1'b1, 32'd1, mk_hash(32'd1), 1'b0, 1'b0);
    complete(1'b1, 32'd2, mk_hash(32'd2), 1'b0, 1'b0);
    complete(1'b1, 32'd3, mk_hash(32'd3), 1'b0, 1'b0);
    read_word(50, d);
    total += 3;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    if (res_level !== 2'd2) begin bad++; $display("FAIL ovf_level got=%0d exp=2", res_level); end
    if (d !== 32'd1) begin bad++; $display("FAIL ovf_head got=%0d exp=1", d); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_cnt = '0; m_fnd = '0; m_ovf = 1'b0;
    total += 4;
    if (overflow !== 1'b0) begin bad++; $display("FAIL clr_overflow got=%0b exp=0", overflow); end
    if (completed_count !== 32'd0) begin bad++; $display("FAIL clr_completed got=%0d exp=0", completed_count); end
    if (found_count !== 32'd0) begin bad++; $display("FAIL clr_found got=%0d exp=0", found_count); end
    if (res_level !== 2'd2) begin bad++; $display("FAIL clr_level got=%0d exp=2", res_level); end
    pop_one();
    complete(1'b1, 32'd4, mk_hash(32'd4), 1'b0, 1'b1);
    total += 2;
    if (completed_count !== 32'd0) begin bad++; $display("FAIL clrev_completed got=%0d exp=0", completed_count); end
    if (res_level !== 2'd2) begin bad++; $display("FAIL clrev_level got=%0d exp=2", res_level); end
    drain("ovf");
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    do_reset();
    complete(1'b1, 32'd5, mk_hash(32'd5), 1'b0, 1'b0);
    read_word(50, d);
    total++;
    if (d !== 32'd5) begin bad++; $display("FAIL arst_pre got=%0d exp=5", d); end
    #3;
    rst = 1'b0;
    #1;
    total += 5;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0b exp=0", res_valid); end
    if (res_level !== 2'd0) begin bad++; $display("FAIL arst_level got=%0d exp=0", res_level); end
    if (rd_data !== 32'd0) begin bad++; $display("FAIL arst_rd_data got=%h exp=0", rd_data); end
    if (completed_count !== 32'd0) begin bad++; $display("FAIL arst_completed got=%0d exp=0", completed_count); end
    if (found_count !== 32'd0) begin bad++; $display("FAIL arst_found got=%0d exp=0", found_count); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_misses();
    test_pop_on_full();
    test_overflow_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha3_result_collector.md
Name: sha3_result_collector

Overview:
- Sits directly downstream of the SHA3 scanner instantiation; watches each scan completion and captures found flag, winning nonce and 25x64-bit hash into a small FIFO.
- Host logic drains results one 32-bit word at a time, so the scanner can be restarted immediately without losing an unread result.
- Also keeps completion/found statistics and a sticky overflow flag for the driver.

Parameters:
- DEPTH, 2, result entries buffered (power of two, 2..8).
- STORE_MISSES, 0, 1: store every completion; 0: store only completions with found=1.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- s_ready  in  1  scanner ready/idle.
- s_found  in  1  scanner found flag.
- s_nonce  in  32  scanner nonce.
- s_hash  in  64x25  scanner hash array.
- res_valid  out  1  FIFO non-empty.
- res_pop  in  1  discard head entry.
- rd_sel  in  6  word select within head entry.
- rd_data  out  32  registered word of head entry.
- res_level  out  $clog2(DEPTH)+1  entries held.
- overflow  out  1  sticky: a completion was dropped.
- completed_count  out  32  completions seen.
- found_count  out  32  completions with found=1.
- clear  in  1  sync clear of overflow and both counters.

Behaviour:
- Reset (rst=0, async): FIFO empty, res_valid=0, res_level=0, rd_data=0, overflow=0, both counters 0, s_ready history register=1 so a ready already high at reset release is not an event.
- Completion event: s_ready=1 this cycle and 0 the previous cycle. Sample s_found/s_nonce/s_hash in that same cycle.
- On event: completed_count+=1; found_count+=1 if s_found. Counters wrap modulo 2^32.
- Store condition: event && (STORE_MISSES || s_found).
- Store with level<DEPTH: write entry at tail; level+1.
- Store with level==DEPTH and no pop in that cycle: entry dropped, overflow<=1, FIFO unchanged.
- Store with level==DEPTH and res_pop=1 in the same cycle: head is popped, new entry accepted, level stays DEPTH, overflow unchanged.
- res_pop while empty: ignored.
- res_valid = (level!=0), combinational from level register.
- rd_data is registered, valid one cycle after rd_sel is applied; always reflects the head entry current at the sampling edge.
- Word map for rd_sel: 2k -> s_hash[k][31:0] (k=0..24); 2k+1 -> s_hash[k][63:32]; 50 -> nonce; 51 -> {31'b0,found}; 52..63 -> 0. An empty FIFO reads 0.
- clear=1: counters and overflow go to 0 next edge. A same-cycle event is lost from the counters, but its store still happens.
- Pointers wrap modulo DEPTH; level is computed separately, so full and empty are unambiguous.
- Latency: event at edge N; res_valid=1 after edge N; first rd_data is available one cycle after rd_sel is applied.

Test Plan:
- Reset, hold s_ready=1, release rst -> no event; res_valid=0, completed_count=0.
- s_ready 1->0->1 with s_found=1, s_nonce=32'hDEADBEEF, s_hash[3]=64'h0123456789ABCDEF -> res_valid=1, level=1; rd_sel=50 -> rd_data=DEADBEEF; rd_sel=6 -> 89ABCDEF; rd_sel=7 -> 01234567; rd_sel=51 -> 1; found_count=1.
- STORE_MISSES=0, three completions with found=0 -> level=0, completed_count=3, found_count=0. Repeat with STORE_MISSES=1 -> level=2 (DEPTH=2), overflow=1.
- Fill to DEPTH=2 with nonces 1 and 2; third completion (nonce 3) with res_pop high in the same cycle -> level=2, overflow=0, reads give nonce 2 then 3.
- Fill to 2 without pop, then a third completion -> overflow=1, head nonce still 1; clear -> overflow=0, counters 0, level still 2.
- Assert rst low mid-operation with 1 entry held -> immediately res_valid=0, rd_data=0, counters 0.
